// File: rtl/enc_quad_gen_if.sv
// Bus bundle for the quadrature encoder generator: run/load controls in,
// quadrature/index/position status out.
interface enc_quad_gen_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             load;
    logic [CNT_W-1:0] period;
    logic             dir;
    logic             a;
    logic             b;
    logic             z;
    logic             step;
    logic [CNT_W-1:0] pos;
    logic             period_err;

    // Stimulus / controller side
    modport master (
        output en, load, period, dir,
        input  a, b, z, step, pos, period_err
    );

    // Generator side
    modport slave (
        input  en, load, period, dir,
        output a, b, z, step, pos, period_err
    );
endinterface

// File: rtl/enc_quad_gen.sv
// Programmable quadrature encoder signal generator. An interval timer
// produces one step every active_period cycles; each step walks the {a,b}
// ring one state in the active direction and moves the position counter
// modulo 4*PPR. Period/dir loads are staged in pending registers and take
// effect only at interval boundaries (or at once while disabled).
module enc_quad_gen #(
    parameter int CNT_W = 16,
    parameter int PPR   = 1000
) (
    input  logic         clk,
    input  logic         rst,
    enc_quad_gen_if.slave qif
);
    localparam int               POS_MOD  = 4 * PPR;
    localparam logic [CNT_W-1:0] POS_LAST = CNT_W'(POS_MOD - 1);
    localparam logic [CNT_W-1:0] PER_MIN  = CNT_W'(2);

    // {a,b} encoding doubles as the state value, so outputs come straight
    // from the state register.
    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q10 = 2'b10,
        Q11 = 2'b11,
        Q01 = 2'b01
    } quad_e;

    quad_e            state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] act_per_q, act_per_d;
    logic             act_dir_q, act_dir_d;
    logic [CNT_W-1:0] pend_per_q, pend_per_d;
    logic             pend_dir_q, pend_dir_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             z_q, z_d;
    logic             step_q, step_d;
    logic             err_q, err_d;

    logic             tc;
    logic             ld_low;
    logic [CNT_W-1:0] ld_per;
    logic [CNT_W-1:0] pos_nxt;
    logic [1:0]       ab;

    // Terminal count of the running interval; active period is never < 2.
    assign tc = qif.en && (timer_q == (act_per_q - CNT_W'(1)));

    // Illegal periods are clamped to the minimum on the way into pending.
    assign ld_low = (qif.period < PER_MIN);
    assign ld_per = ld_low ? PER_MIN : qif.period;

    // Position one step away in the active direction, wrapping modulo 4*PPR.
    always_comb begin
        pos_nxt = pos_q;
        if (!act_dir_q) begin
            pos_nxt = (pos_q == POS_LAST) ? '0 : pos_q + CNT_W'(1);
        end else begin
            pos_nxt = (pos_q == '0) ? POS_LAST : pos_q - CNT_W'(1);
        end
    end

    // Quadrature state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= Q00;
        end else begin
            state_q <= state_d;
        end
    end

    // Quadrature next state: one ring position per step; a direction change
    // just reverses the walk, so only one bit ever toggles.
    always_comb begin
        state_d = state_q;
        if (tc) begin
            if (!act_dir_q) begin
                unique case (state_q)
                    Q00: state_d = Q10;
                    Q10: state_d = Q11;
                    Q11: state_d = Q01;
                    Q01: state_d = Q00;
                    default: state_d = Q00;
                endcase
            end else begin
                unique case (state_q)
                    Q00: state_d = Q01;
                    Q01: state_d = Q11;
                    Q11: state_d = Q10;
                    Q10: state_d = Q00;
                    default: state_d = Q00;
                endcase
            end
        end
    end

    // Timer, position, index, step strobe and period/dir staging.
    always_comb begin
        timer_d    = timer_q;
        act_per_d  = act_per_q;
        act_dir_d  = act_dir_q;
        pend_per_d = pend_per_q;
        pend_dir_d = pend_dir_q;
        pos_d      = pos_q;
        z_d        = z_q;
        step_d     = 1'b0;
        err_d      = err_q;

        if (!qif.en) begin
            // Disabled: restart the interval and let pending settle in.
            timer_d   = '0;
            act_per_d = pend_per_q;
            act_dir_d = pend_dir_q;
        end else if (tc) begin
            // Step boundary: the finished interval used the old settings;
            // a load on this same cycle governs the next interval directly.
            timer_d   = '0;
            step_d    = 1'b1;
            pos_d     = pos_nxt;
            z_d       = (pos_nxt == '0);
            act_per_d = qif.load ? ld_per  : pend_per_q;
            act_dir_d = qif.load ? qif.dir : pend_dir_q;
        end else begin
            timer_d = timer_q + CNT_W'(1);
        end

        if (qif.load) begin
            pend_per_d = ld_per;
            pend_dir_d = qif.dir;
            err_d      = ld_low;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q    <= '0;
            act_per_q  <= PER_MIN;
            act_dir_q  <= 1'b0;
            pend_per_q <= PER_MIN;
            pend_dir_q <= 1'b0;
            pos_q      <= '0;
            z_q        <= 1'b0;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            act_per_q  <= act_per_d;
            act_dir_q  <= act_dir_d;
            pend_per_q <= pend_per_d;
            pend_dir_q <= pend_dir_d;
            pos_q      <= pos_d;
            z_q        <= z_d;
            step_q     <= step_d;
            err_q      <= err_d;
        end
    end

    assign ab             = state_q;
    assign qif.a          = ab[1];
    assign qif.b          = ab[0];
    assign qif.z          = z_q;
    assign qif.step       = step_q;
    assign qif.pos        = pos_q;
    assign qif.period_err = err_q;
endmodule

// File: tb/tb_enc_quad_gen.sv
// Self-checking bench for enc_quad_gen: directed scenarios followed by a
// randomized run, all compared every cycle against an abstract model in
// which {a,b} is simply a function of position modulo 4.
module tb_enc_quad_gen;
    localparam int CNT_W = 16;
    localparam int PPR   = 1000;
    localparam int M     = 4 * PPR;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    enc_quad_gen_if #(.CNT_W(CNT_W)) qif ();

    enc_quad_gen #(.CNT_W(CNT_W), .PPR(PPR)) dut (
        .clk (clk),
        .rst (rst),
        .qif (qif.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int   m_cnt, m_per, m_dir, m_pper, m_pdir, m_pos;
    logic m_z, m_step, m_err;
    int   cyc_n = 0;
    int   last_step;
    int   gap;
    logic [1:0] prev_ab;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ring order seen going forward from position 0.
    function automatic logic [1:0] ab_of(input int p);
        case (p % 4)
            0: ab_of = 2'b00;
            1: ab_of = 2'b10;
            2: ab_of = 2'b11;
            default: ab_of = 2'b01;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_per = 2; m_dir = 0; m_pper = 2; m_pdir = 0;
        m_pos = 0; m_z = 0; m_step = 0; m_err = 0;
        prev_ab = 2'b00;
        last_step = -100;
    endtask

    task automatic model_edge();
        int lp;
        if (rst) begin
            model_reset();
            return;
        end
        lp = (int'(qif.period) < 2) ? 2 : int'(qif.period);
        m_step = 0;
        if (!qif.en) begin
            m_cnt = 0;
            m_per = m_pper;
            m_dir = m_pdir;
        end else if (m_cnt + 1 == m_per) begin
            m_pos  = m_dir ? (m_pos + M - 1) % M : (m_pos + 1) % M;
            m_z    = (m_pos == 0);
            m_step = 1;
            m_cnt  = 0;
            m_per  = qif.load ? lp : m_pper;
            m_dir  = qif.load ? int'(qif.dir) : m_pdir;
        end else begin
            m_cnt++;
        end
        if (qif.load) begin
            m_pper = lp;
            m_pdir = int'(qif.dir);
            m_err  = (int'(qif.period) < 2);
        end
    endtask

    task automatic check_all();
        logic [1:0] ab;
        ab = {qif.a, qif.b};
        chk("ab", ab, ab_of(m_pos));
        chk("z", qif.z, m_z);
        chk("step", qif.step, m_step);
        chk("pos", qif.pos, m_pos);
        chk("period_err", qif.period_err, m_err);
        chk("ab_single_toggle", ($countones(ab ^ prev_ab) <= 1), 1);
        prev_ab = ab;
        if (qif.step) begin
            gap = cyc_n - last_step;
            last_step = cyc_n;
            chk("step_spacing_min", (gap >= 2), 1);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        cyc_n++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic en, input logic ld, input int per, input logic d);
        qif.en     = en;
        qif.load   = ld;
        qif.period = CNT_W'(per);
        qif.dir    = d;
    endtask

    task automatic wait_step(input int maxc, input string tag, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!qif.step && n < maxc);
        chk(tag, qif.step, 1);
    endtask

    // Set up a period/dir while disabled so it is active before running.
    task automatic preload(input int per, input logic d);
        drive(0, 1, per, d); cyc();
        drive(0, 0, per, d); cyc();
    endtask

    initial begin
        int n, held;
        logic [1:0] exp_ab [4];
        exp_ab[0] = 2'b10; exp_ab[1] = 2'b11; exp_ab[2] = 2'b01; exp_ab[3] = 2'b00;

        rst = 1'b1;
        drive(0, 0, 0, 0);
        model_reset();
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("reset_pos", qif.pos, 0);
        chk("reset_ab", {qif.a, qif.b}, 0);

        // forward run at period 5
        preload(5, 0);
        drive(1, 0, 5, 0);
        for (int k = 0; k < 4; k++) begin
            wait_step(20, "fwd_step_seen", n);
            chk("fwd_gap", n, 5);
            chk("fwd_ab", {qif.a, qif.b}, exp_ab[k]);
            chk("fwd_pos", qif.pos, k + 1);
        end

        // asynchronous reset in the middle of an interval
        cyc(); cyc();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ab", {qif.a, qif.b}, 0);
        chk("async_rst_z", qif.z, 0);
        chk("async_rst_step", qif.step, 0);
        chk("async_rst_pos", qif.pos, 0);
        chk("async_rst_err", qif.period_err, 0);
        model_reset();
        drive(0, 0, 0, 0);
        cyc();
        rst = 1'b0;
        repeat (20) begin
            cyc();
            chk("idle_no_step", qif.step, 0);
        end

        // reverse wrap and index at period 3
        preload(3, 1);
        drive(1, 0, 3, 1);
        wait_step(10, "rev_first_seen", n);
        chk("rev_first_gap", n, 3);
        chk("rev_first_ab", {qif.a, qif.b}, 2'b01);
        chk("rev_first_pos", qif.pos, M - 1);
        for (int k = 0; k < M - 2; k++) wait_step(10, "rev_step_seen", n);
        wait_step(10, "rev_zero_seen", n);
        chk("rev_zero_pos", qif.pos, 0);
        chk("rev_zero_z", qif.z, 1);
        cyc(); chk("z_hold1", qif.z, 1);
        cyc(); chk("z_hold2", qif.z, 1);
        wait_step(10, "rev_wrap_seen", n);
        chk("rev_wrap_n", n, 1);
        chk("rev_wrap_pos", qif.pos, M - 1);
        chk("rev_wrap_z", qif.z, 0);

        // mid-interval reload 4 -> 10, then direction flip
        preload(4, 0);
        drive(1, 0, 4, 0);
        wait_step(20, "reload_first", n);
        chk("reload_p4_gap", n, 4);
        cyc(); cyc();
        drive(1, 1, 10, 0); cyc();
        drive(1, 0, 10, 0);
        wait_step(20, "reload_old_seen", n);
        chk("reload_old_gap", gap, 4);
        wait_step(20, "reload_new_seen", n);
        chk("reload_new_gap", gap, 10);
        held = int'(qif.pos);
        repeat (3) cyc();
        drive(1, 1, 10, 1); cyc();
        drive(1, 0, 10, 1);
        wait_step(20, "flip_old_seen", n);
        chk("flip_old_pos", qif.pos, (held + 1) % M);
        wait_step(20, "flip_new_seen", n);
        chk("flip_new_pos", qif.pos, held);
        chk("flip_gap", gap, 10);

        // clamp of illegal periods
        drive(1, 1, 0, 0); cyc();
        drive(1, 1, 1, 0); cyc();
        drive(1, 0, 1, 0);
        repeat (3) wait_step(20, "clamp_seen", n);
        chk("clamp_gap", gap, 2);
        chk("clamp_err", qif.period_err, 1);
        drive(1, 1, 7, 0); cyc();
        drive(1, 0, 7, 0);
        chk("clamp_err_clear", qif.period_err, 0);
        repeat (2) wait_step(20, "p7_seen", n);
        chk("p7_gap", gap, 7);

        // disable at timer=2 of period 6, then resume
        drive(1, 1, 6, 0); cyc();
        drive(1, 0, 6, 0);
        repeat (2) wait_step(20, "p6_seen", n);
        chk("p6_gap", gap, 6);
        cyc(); cyc();
        drive(0, 0, 6, 0);
        held = int'(qif.pos);
        repeat (5) begin
            cyc();
            chk("dis_pos_hold", qif.pos, held);
            chk("dis_no_step", qif.step, 0);
        end
        drive(1, 0, 6, 0);
        wait_step(20, "resume_seen", n);
        chk("resume_n", n, 6);
        chk("resume_pos", qif.pos, (held + 1) % M);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                  int'($urandom_range(0, 8)), $urandom_range(0, 1) == 1);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
